// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 2-flop synchronizer, mid-bit sampling with a latched
// clocks-per-bit value, one-cycle write / frame-error strobes.
module uart_byte_rx #(
    parameter int unsigned MIN_BAUD_CLKS = 16
) (
    input  logic        i_clk,
    input  logic        n_btn_rst,
    input  logic [30:0] i_setup,
    input  logic        i_uart_rx,
    output logic        o_wr,
    output logic [7:0]  o_data,
    output logic        o_frame_err,
    output logic        o_busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    localparam logic [23:0] MIN_N = 24'(MIN_BAUD_CLKS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_sync1;
    logic        r_rx_s;
    logic        r_rx_prev;
    logic [23:0] r_cnt;
    logic [23:0] r_n;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;

    logic [23:0] w_n_eff;
    logic        w_fall;
    logic        w_tick;
    logic        w_load_start;
    logic        w_reload;
    logic        w_shift;
    logic        w_done_ok;
    logic        w_done_err;
    logic        w_unused_setup;

    assign w_unused_setup = ^i_setup[30:24];
    assign w_n_eff        = (i_setup[23:0] < MIN_N) ? MIN_N : i_setup[23:0];
    assign w_fall         = r_rx_prev & ~r_rx_s;
    assign w_tick         = (r_cnt == '0);
    assign o_busy         = (r_state != IDLE);

    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            r_sync1   <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= i_uart_rx;
            r_rx_s    <= r_sync1;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_start = 1'b0;
        w_reload     = 1'b0;
        w_shift      = 1'b0;
        w_done_ok    = 1'b0;
        w_done_err   = 1'b0;
        unique case (r_state)
            IDLE: begin
                // prev flop must have seen high, so a line held low after BREAK cannot retrigger
                if (w_fall) begin
                    w_state_nxt  = START;
                    w_load_start = 1'b1;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = DATA;
                        w_reload    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_shift  = 1'b1;
                    w_reload = 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_tick) begin
                    if (r_rx_s) begin
                        w_done_ok   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_done_err  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (r_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // First sample lands floor(N/2) cycles after the edge, then every N cycles.
    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            r_cnt   <= '0;
            r_n     <= MIN_N;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            if (w_load_start) begin
                r_n   <= w_n_eff;
                r_cnt <= (w_n_eff >> 1) - 24'd1;
                r_bit <= '0;
            end else if (w_reload) begin
                r_cnt <= r_n - 24'd1;
            end else if (r_state != IDLE && r_state != BREAK && !w_tick) begin
                r_cnt <= r_cnt - 24'd1;
            end
            if (w_shift) begin
                r_shift <= {r_rx_s, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge n_btn_rst) begin
        if (!n_btn_rst) begin
            o_wr        <= 1'b0;
            o_frame_err <= 1'b0;
            o_data      <= '0;
        end else begin
            o_wr        <= w_done_ok;
            o_frame_err <= w_done_err;
            if (w_done_ok) begin
                o_data <= r_shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed self-checking bench for uart_byte_rx: clean frames, glitch, framing
// error with break, back-to-back frames, mid-frame reset and N clamping.
module tb_uart_byte_rx;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic [30:0] setup = 31'd16;
    logic        rx = 1'b1;
    logic        o_wr;
    logic [7:0]  o_data;
    logic        o_frame_err;
    logic        o_busy;

    uart_byte_rx #(.MIN_BAUD_CLKS(16)) dut (
        .i_clk       (clk),
        .n_btn_rst   (n_rst),
        .i_setup     (setup),
        .i_uart_rx   (rx),
        .o_wr        (o_wr),
        .o_data      (o_data),
        .o_frame_err (o_frame_err),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int         wr_cnt = 0;
    int         fe_cnt = 0;
    logic [7:0] wr_data [0:31];
    int         wr_cyc  [0:31];

    always @(negedge clk) begin
        if (o_wr && wr_cnt < 32) begin
            wr_data[wr_cnt] = o_data;
            wr_cyc[wr_cnt]  = cyc;
            wr_cnt++;
        end
        if (o_frame_err) fe_cnt++;
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // chg_bit < 0 means setup is left alone during the frame
    task automatic send_frame(input logic [7:0] b, input int n, input logic stop_val,
                              input int stop_len, input int chg_bit, input logic [30:0] chg_val);
        rx = 1'b0;
        repeat (n) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (i == chg_bit) setup = chg_val;
            rx = b[i];
            repeat (n) @(negedge clk);
        end
        rx = stop_val;
        repeat (stop_len) @(negedge clk);
    endtask

    int base;
    int fbase;
    int t0;
    int lat;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wr",   32'(o_wr),        32'd0);
        chk("rst_data", 32'(o_data),      32'h00);
        chk("rst_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_busy", 32'(o_busy),      32'd0);
        n_rst = 1'b1;
        idle(10);

        base = wr_cnt; fbase = fe_cnt;
        t0 = cyc;
        send_frame(8'hA5, 16, 1'b1, 16, -1, '0);
        idle(4);
        chk("a5_wr_count", 32'(wr_cnt - base), 32'd1);
        chk("a5_data",     32'(wr_data[base]), 32'hA5);
        chk("a5_out",      32'(o_data),        32'hA5);
        chk("a5_no_ferr",  32'(fe_cnt - fbase), 32'd0);
        lat = wr_cyc[base] - t0;
        chk("a5_latency_154_156", 32'(lat >= 154 && lat <= 156), 32'd1);

        base = wr_cnt; fbase = fe_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        chk("glitch_busy_hi", 32'(o_busy), 32'd1);
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        chk("glitch_busy_lo", 32'(o_busy),          32'd0);
        chk("glitch_no_wr",   32'(wr_cnt - base),   32'd0);
        chk("glitch_no_ferr", 32'(fe_cnt - fbase),  32'd0);

        base = wr_cnt; fbase = fe_cnt;
        send_frame(8'h00, 16, 1'b0, 320, -1, '0);
        chk("brk_busy_in_break", 32'(o_busy), 32'd1);
        idle(32);
        chk("brk_ferr_count", 32'(fe_cnt - fbase), 32'd1);
        chk("brk_no_wr",      32'(wr_cnt - base),  32'd0);
        chk("brk_data_held",  32'(o_data),         32'hA5);
        chk("brk_busy_lo",    32'(o_busy),         32'd0);
        send_frame(8'h5A, 16, 1'b1, 16, -1, '0);
        idle(4);
        chk("brk_5a_wr",   32'(wr_cnt - base),  32'd1);
        chk("brk_5a_data", 32'(wr_data[base]),  32'h5A);
        chk("brk_5a_ferr", 32'(fe_cnt - fbase), 32'd1);

        setup = {7'h7F, 24'd16};
        base = wr_cnt; fbase = fe_cnt;
        send_frame(8'h01, 16, 1'b1, 16, -1, '0);
        send_frame(8'hFF, 16, 1'b1, 16, -1, '0);
        idle(4);
        chk("b2b_wr_count", 32'(wr_cnt - base),       32'd2);
        chk("b2b_first",    32'(wr_data[base]),       32'h01);
        chk("b2b_second",   32'(wr_data[base + 1]),   32'hFF);
        chk("b2b_no_ferr",  32'(fe_cnt - fbase),      32'd0);

        setup = 31'd16;
        base = wr_cnt; fbase = fe_cnt;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (16) @(negedge clk);
        end
        rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_mid_busy_before", 32'(o_busy), 32'd1);
        n_rst = 1'b0;
        #1;
        chk("rst_mid_wr",   32'(o_wr),        32'd0);
        chk("rst_mid_data", 32'(o_data),      32'h00);
        chk("rst_mid_ferr", 32'(o_frame_err), 32'd0);
        chk("rst_mid_busy", 32'(o_busy),      32'd0);
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        idle(40);
        chk("rst_mid_no_strobe", 32'(wr_cnt - base + fe_cnt - fbase), 32'd0);
        send_frame(8'h3C, 16, 1'b1, 16, -1, '0);
        idle(4);
        chk("rst_3c_wr",   32'(wr_cnt - base), 32'd1);
        chk("rst_3c_data", 32'(wr_data[base]), 32'h3C);

        setup = 31'd5;
        base = wr_cnt; fbase = fe_cnt;
        send_frame(8'hC3, 16, 1'b1, 16, -1, '0);
        idle(4);
        chk("clamp_c3_data", 32'(wr_data[base]), 32'hC3);
        setup = 31'd5;
        send_frame(8'hE1, 16, 1'b1, 16, 3, 31'd100);
        idle(4);
        chk("clamp_wr_count", 32'(wr_cnt - base),     32'd2);
        chk("midchg_e1_data", 32'(wr_data[base + 1]), 32'hE1);
        chk("clamp_no_ferr",  32'(fe_cnt - fbase),    32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
